// File: rtl/spi_slave_param.sv
// SPI slave front-end for the single-port RAM path: deserialises {cmd, payload} frames and
// serialises RAM read data on MISO. Optional frame_err output enabled by SPI_FRAME_ERR_EN.
module spi_slave_param #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    localparam int PAY_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W,
    localparam int FRAME_W = PAY_W + 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic               frame_err
`endif
);

    localparam int CNT_W = $clog2(FRAME_W + DATA_W + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W + DATA_W);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-2:0] rx_shift;
    logic [DATA_W-1:0]  tx_shift;
    logic               rd_addr_seen;
    logic               tx_done;
    logic [FRAME_W-1:0] frame_next;

    assign frame_next = {rx_shift, MOSI};

`ifdef SPI_FRAME_ERR_EN
    // A frame is still open until its last bit, and a read until all data bits are out.
    logic frame_open;
    assign frame_open = (state inside {WRITE, READ_ADD, READ_DATA}) &&
                        ((cnt < FRAME_CNT) || (state == READ_DATA && !tx_done));
`endif

    // cnt: 1..FRAME_W while receiving, FRAME_W waiting for tx_valid,
    // FRAME_W+1..FRAME_W+DATA_W while shifting MISO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            MISO         <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            rx_shift     <= '0;
            cnt          <= '0;
            tx_shift     <= '0;
            rd_addr_seen <= 1'b0;
            tx_done      <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err    <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            MISO     <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            if (SS_n) begin
`ifdef SPI_FRAME_ERR_EN
                frame_err <= frame_open;
`endif
                state    <= IDLE;
                cnt      <= '0;
                tx_shift <= '0;
                tx_done  <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= CHK_CMD;
                    CHK_CMD: begin
                        rx_shift <= (FRAME_W-1)'(MOSI);
                        cnt      <= CNT_W'(1);
                        if (!MOSI)             state <= WRITE;
                        else if (rd_addr_seen) state <= READ_DATA;
                        else                   state <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (cnt < FRAME_CNT) begin
                            rx_shift <= frame_next[FRAME_W-2:0];
                            cnt      <= cnt + CNT_W'(1);
                            if (cnt == FRAME_LAST) begin
                                rx_valid <= 1'b1;
                                rx_data  <= frame_next;
                                if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                                if (state == READ_DATA) rd_addr_seen <= 1'b0;
                            end
                        end else if (state == READ_DATA && !tx_done) begin
                            if (cnt == FRAME_CNT) begin
                                if (tx_valid) begin
                                    tx_shift <= tx_data;
                                    cnt      <= cnt + CNT_W'(1);
                                end
                            end else begin
                                MISO     <= tx_shift[DATA_W-1];
                                tx_shift <= tx_shift << 1;
                                if (cnt == SHIFT_LAST) tx_done <= 1'b1;
                                else                   cnt     <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: a cycle-schedule model of expected rx/MISO activity checked every
// negedge, plus literal checks; a second instance covers ADDR_W=10, DATA_W=6.
module tb_spi_slave_param;

    localparam int DW = 8;
    localparam int PW = 8;
    localparam int FW = PW + 2;

    logic          clk = 1'b0;
    logic          rst_n, ss_n, mosi, miso, rx_valid, tx_valid;
    logic [FW-1:0] rx_data;
    logic [DW-1:0] tx_data;
    logic          ss2, mosi2, miso2, rx_valid2, tx_valid2;
    logic [11:0]   rx_data2;
    logic [5:0]    tx_data2;
`ifdef SPI_FRAME_ERR_EN
    logic          frame_err, err2;
`endif

    spi_slave_param u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (ss_n),
        .MOSI     (mosi),
        .MISO     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    spi_slave_param #(.ADDR_W(10), .DATA_W(6)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (ss2),
        .MOSI     (mosi2),
        .MISO     (miso2),
        .rx_data  (rx_data2),
        .rx_valid (rx_valid2),
        .tx_data  (tx_data2),
        .tx_valid (tx_valid2)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(err2)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    bit run = 1'b0;

    // Model state: expected events keyed by the negedge cycle they are visible on.
    logic [FW-1:0] exp_rx [int];
    bit            exp_miso [int];
`ifdef SPI_FRAME_ERR_EN
    bit            exp_err [int];
`endif
    logic [FW-1:0] hold = '0;
    bit            m_seen = 1'b0;
    int            m_kind = -1;
    bit            m_done = 1'b0;
    bit            m_open_err = 1'b0;
    logic [DW-1:0] got;
    logic [5:0]    got2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            if (exp_rx.exists(cyc)) begin
                hold = exp_rx[cyc];
                chk("rx_valid", 32'(rx_valid), 32'd1);
            end else begin
                chk("rx_valid", 32'(rx_valid), 32'd0);
            end
            chk("rx_data", 32'(rx_data), 32'(hold));
            chk("miso", 32'(miso), exp_miso.exists(cyc) ? 32'(exp_miso[cyc]) : 32'd0);
`ifdef SPI_FRAME_ERR_EN
            chk("frame_err", 32'(frame_err), exp_err.exists(cyc) ? 32'd1 : 32'd0);
`endif
        end
    end

    task automatic step(input bit ss, input bit mo, input bit tv, input logic [DW-1:0] td);
        @(negedge clk);
        ss_n = ss;
        mosi = mo;
        tx_valid = tv;
        tx_data = td;
    endtask

    // One select cycle, then nbits bits; bits past the frame are random and must be ignored.
    task automatic send_frame(input logic [1:0] cmd, input logic [PW-1:0] pay, input int nbits);
        logic [FW-1:0] f;
        int kind;
        bit b;
        f = {cmd, pay};
        kind = !cmd[1] ? 0 : (m_seen ? 2 : 1);
        m_kind = kind;
        m_done = 1'b0;
        m_open_err = 1'b0;
        step(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < nbits; i++) begin
            b = 1'($urandom);
            if (i < FW) b = f[FW-1-i];
            step(1'b0, b, i == 3, '1);
            if (i == FW - 1) begin
                exp_rx[cyc+1] = f;
                m_done = 1'b1;
                if (kind == 1) m_seen = 1'b1;
                if (kind == 2) m_seen = 1'b0;
                m_open_err = (kind == 2);
            end
        end
        if (!m_done && nbits > 0) m_open_err = 1'b1;
    endtask

    task automatic end_frame();
        step(1'b1, 1'b0, 1'b0, '0);
        if (m_open_err) begin
`ifdef SPI_FRAME_ERR_EN
            exp_err[cyc+1] = 1'b1;
`endif
            m_open_err = 1'b0;
        end
    endtask

    // Pulses tx_valid after pre cycles; MISO bits are collected from the expected window.
    task automatic do_read(input logic [DW-1:0] d, input int pre, input int nsteps,
                           output logic [DW-1:0] bits);
        int k;
        bit active;
        active = (m_kind == 2) && m_done;
        bits = '0;
        for (int i = 0; i < pre; i++) step(1'b0, 1'($urandom), 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, d);
        k = cyc;
        if (active) begin
            for (int j = 0; j < DW; j++) exp_miso[k+2+j] = d[DW-1-j];
            m_kind = -1;
        end
        for (int j = 0; j < nsteps; j++) begin
            step(1'b0, 1'($urandom), j == 3, ~d);
            if (j >= 1 && j <= DW) bits[DW-j] = miso;
        end
        if (active && nsteps >= DW) m_open_err = 1'b0;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        ss_n = 1'b1;
        tx_valid = 1'b0;
        exp_rx.delete();
        exp_miso.delete();
`ifdef SPI_FRAME_ERR_EN
        exp_err.delete();
`endif
        hold = '0;
        m_seen = 1'b0;
        m_kind = -1;
        m_done = 1'b0;
        m_open_err = 1'b0;
        #1;
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_miso", 32'(miso), 32'd0);
        step(1'b1, 1'b0, 1'b0, '0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic frame2(input logic [11:0] f);
        @(negedge clk);
        ss2 = 1'b0;
        mosi2 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            mosi2 = f[11-i];
        end
        @(negedge clk);
        mosi2 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        ss_n = 1'b1;
        mosi = 1'b0;
        tx_valid = 1'b0;
        tx_data = '0;
        ss2 = 1'b1;
        mosi2 = 1'b0;
        tx_valid2 = 1'b0;
        tx_data2 = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("init_rx_valid", 32'(rx_valid), 32'd0);
        chk("init_rx_data", 32'(rx_data), 32'd0);
        chk("init_miso", 32'(miso), 32'd0);
        chk("init_rx_data2", 32'(rx_data2), 32'd0);
        run = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Write frame with trailing bits; tx_valid in a write frame must not shift.
        send_frame(2'b00, 8'hA5, FW + 2);
        chk("t1_rx", 32'(rx_data), 32'h0A5);
        do_read(8'h5A, 1, DW + 2, got);
        chk("t1_no_miso", 32'(got), 32'd0);
        end_frame();

        send_frame(2'b01, 8'h3C, FW);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("t2_rx", 32'(rx_data), 32'h13C);
        end_frame();

        send_frame(2'b10, 8'h12, FW + 1);
        chk("t3a_rx", 32'(rx_data), 32'h212);
        end_frame();
        send_frame(2'b11, 8'h00, FW + 1);
        chk("t3b_rx", 32'(rx_data), 32'h300);
        do_read(8'hC3, 2, DW + 2, got);
        chk("t3_miso", 32'(got), 32'hC3);
        end_frame();

        // A write between address and data frames leaves rd_addr_seen set.
        send_frame(2'b10, 8'h55, FW);
        end_frame();
        send_frame(2'b01, 8'h66, FW);
        end_frame();
        send_frame(2'b10, 8'h77, FW);
        do_read(8'h5A, 0, DW + 2, got);
        chk("seen_miso", 32'(got), 32'h5A);
        end_frame();

        // Aborts: after 5 bits, and on the last bit.
        send_frame(2'b00, 8'hFF, 5);
        end_frame();
        send_frame(2'b00, 8'h81, FW - 1);
        end_frame();
        chk("t4_hold", 32'(rx_data), 32'h277);

        // Read aborted while waiting for tx_valid; next 1x frame is an address frame.
        send_frame(2'b10, 8'h01, FW);
        end_frame();
        send_frame(2'b11, 8'h02, FW);
        end_frame();
        send_frame(2'b10, 8'h03, FW + 1);
        do_read(8'hFF, 0, DW + 2, got);
        chk("abort_no_miso", 32'(got), 32'd0);
        end_frame();

        // Reset in the middle of a MISO shift.
        send_frame(2'b11, 8'h04, FW);
        do_read(8'hFF, 0, 4, got);
        async_reset();
        send_frame(2'b10, 8'h09, FW + 1);
        chk("t5_rx", 32'(rx_data), 32'h209);
        end_frame();
        async_reset();
        send_frame(2'b10, 8'h0A, FW + 1);
        do_read(8'hFF, 0, DW + 2, got);
        chk("t5_seen_cleared", 32'(got), 32'd0);
        end_frame();

        // ADDR_W=10, DATA_W=6 instance.
        frame2(12'h2AB);
        chk("t6_valid", 32'(rx_valid2), 32'd1);
        chk("t6_rx", 32'(rx_data2), 32'h2AB);
        @(negedge clk) ss2 = 1'b1;
        frame2(12'h915);
        chk("t6_radd", 32'(rx_data2), 32'h915);
        @(negedge clk) ss2 = 1'b1;
        frame2(12'hC00);
        chk("t6_rdata", 32'(rx_data2), 32'hC00);
        tx_valid2 = 1'b1;
        tx_data2 = 6'h2D;
        @(negedge clk) tx_valid2 = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            got2[5-j] = miso2;
        end
        chk("t6_miso", 32'(got2), 32'h2D);
        @(negedge clk);
        chk("t6_miso_idle", 32'(miso2), 32'd0);
        ss2 = 1'b1;
`ifdef SPI_FRAME_ERR_EN
        @(negedge clk);
        chk("t6_err", 32'(err2), 32'd0);
`endif
        repeat (3) step(1'b1, 1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
